rv32i_mc_ctrl: RTL and testbench
================================

# rv32i_mc_ctrl

Multicycle control FSM for the RV32I core. It decodes the latched instruction word and steps the registered ALU through its execution stages by driving `current_stage`, `opcode`, `AluControl` and `PCSrc`. It also drives the operand muxes, register-file and PC/IR write enables, and the instruction/data memory handshake. It sits between the instruction register and the ALU, register file and memory interface, and is the only sequencer of the ALU.

## Interface

- No parameters.
- `clk` — input, 1 bit. Rising-edge clock.
- `reset` — input, 1 bit. Asynchronous, active-high.
- `instr` — input, 32 bits. Instruction register contents.
- `Cond_Chk` — input, 1 bit. ALU branch-compare result.
- `mem_ready` — input, 1 bit. Memory completes the current request this cycle.
- `current_stage` — output, 5 bits. State encoding, fed to the ALU.
- `opcode` — output, 7 bits. Equal to `instr[6:0]`.
- `AluControl` — output, 4 bits. ALU operation.
- `PCSrc` — output, 1 bit. PC source: 1 selects `AluOut`, 0 selects `AluResult`.
- `ALUSrcA` — output, 2 bits. 0 = PC, 1 = OldPC, 2 = rs1.
- `ALUSrcB` — output, 2 bits. 0 = rs2, 1 = imm, 2 = constant 4.
- `ImmSrc` — output, 3 bits. 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- `ResultSrc` — output, 2 bits. Register write-back data: 0 = AluResult, 1 = mem rdata, 2 = PC.
- `PCWrite`, `IRWrite`, `RegWrite` — output, 1 bit each. Write enables.
- `mem_req`, `mem_we`, `AdrSrc` — output, 1 bit each. Memory request, write strobe, and address select (0 = PC, 1 = AluResult).
- `illegal` — output, 1 bit. Sticky: an unknown opcode was decoded.
- `instret` — output, 32 bits. Retired-instruction counter.

## Operation

- The state register holds the `current_stage` value. All other outputs are Moore decodes of the state and `instr`.
- States and encodings:
  - FETCH = 0, DECODE = 1, EXEC_R = 2, ALU_WB = 3, LOAD_ADDR = 4, MEM_READ = 5, MEM_WB = 6, EXEC_I = 7
  - JAL_ADDR = 8, MEM_WRITE = 9, LUI = 10, AUIPC = 11, JUMP_WB = 12, JALR_ADDR = 13
  - BRANCH_UPD = 14, STORE_ADDR = 15, BRANCH_CMP = 16, ILLEGAL = 17
- FETCH:
  - Drives `mem_req=1`, `AdrSrc=0`, `ALUSrcA=PC`, `ALUSrcB=4`, `AluControl=0000`.
  - `IRWrite = mem_ready`.
  - Stays in FETCH while `mem_ready=0`; goes to DECODE when `mem_ready=1`.
- DECODE:
  - Drives `PCWrite=1`, `PCSrc=0` (PC ← PC+4).
  - Drives `ALUSrcA=OldPC`, `ALUSrcB=imm`, `ImmSrc=B`, so the ALU computes the branch target.
- Dispatch from DECODE on opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 → LOAD_ADDR
  - 0100011 → STORE_ADDR
  - 1101111 → JAL_ADDR
  - 1100111 → JALR_ADDR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - 1100011 → BRANCH_CMP
  - any other → ILLEGAL
- Operand selects:
  - EXEC_R: rs1, rs2.
  - EXEC_I, LOAD_ADDR, JALR_ADDR: rs1, imm(I).
  - STORE_ADDR: rs1, imm(S).
  - JAL_ADDR: OldPC, imm(J).
  - AUIPC: OldPC, imm(U).
  - LUI: `ALUSrcB` = imm(U).
  - BRANCH_CMP: rs1, rs2.
- Successors and actions:
  - EXEC_R, EXEC_I, LUI, AUIPC → ALU_WB.
  - ALU_WB: `RegWrite=1`, `ResultSrc=0`, then → FETCH.
  - LOAD_ADDR → MEM_READ.
  - MEM_READ: `mem_req=1`, `AdrSrc=1`; holds until `mem_ready=1`, then → MEM_WB.
  - MEM_WB: `RegWrite=1`, `ResultSrc=1`, then → FETCH.
  - STORE_ADDR → MEM_WRITE.
  - MEM_WRITE: `mem_req=1`, `mem_we=1`, `AdrSrc=1`; holds until `mem_ready=1`, then → FETCH.
  - JAL_ADDR, JALR_ADDR → JUMP_WB.
  - JUMP_WB: `RegWrite=1`, `ResultSrc=2` (PC, already PC+4), `PCWrite=1`, `PCSrc=0` (AluResult = target), then → FETCH.
  - BRANCH_CMP → BRANCH_UPD.
  - BRANCH_UPD: `PCSrc=1`, `PCWrite=Cond_Chk`, then → FETCH.
  - ILLEGAL: terminal. Sets `illegal`; all enables and `mem_req` are 0 until reset.
- AluControl:
  - R-type: `{instr[30], funct3}`.
  - I-type: `{instr[30] & (funct3==101), funct3}`. This stops addi from becoming sub.
  - BRANCH_CMP: `{1, funct3}`.
  - All other states: 0000.
- Outputs not listed for a state are 0.
- `instret` increments by 1 on every transition into FETCH from a non-FETCH state, except from ILLEGAL. It wraps at 2^32 − 1 → 0.

## Timing

- Reset (asynchronous, any cycle, including mid-memory-wait):
  - state = FETCH, `illegal` = 0, `instret` = 0.
  - While `reset` is high, `mem_req`, `IRWrite`, `PCWrite`, `RegWrite` and `mem_we` are forced to 0.
  - The first fetch request is issued on the first cycle after reset deasserts.
- Minimum cycles per instruction, with `mem_ready` high on the first cycle of each request:
  - R, I, LUI, AUIPC: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 4.
  - JAL / JALR: 4.
- Each cycle that `mem_ready` is low adds one cycle.
- `mem_req` stays high and its address stays stable until the cycle in which `mem_ready=1` is sampled. The FSM leaves the state on that same edge.
- ALU latency is one cycle:
  - A result computed in state S appears in `AluResult` in state S+1 and in `AluOut` in state S+2.
  - BRANCH_UPD therefore sees the DECODE target on `AluOut` and the BRANCH_CMP compare on `Cond_Chk`.
- Back-to-back instructions: FETCH follows the write-back or PC-update state with no gap cycle.

## Test plan

- **R-type add:** reset, then fetch `add x3,x1,x2` (x1=5, x2=7) with `mem_ready` high.
  - Required: states 0 → 1 → 2 → 3.
  - `RegWrite` high in stage 3 with AluResult = 12.
  - `AluControl` = 0000; `instret` = 1.
- **Shift right arithmetic:** `sub` gives `AluControl` = 1000. `srai x1,x1,3` gives 1101. `addi x1,x0,-1024` (bit 30 set) gives 0000.
- **Branch taken and not taken:**
  - `beq` with equal operands, offset +16 at PC 0x100: `PCWrite` high in stage 14 with `PCSrc`=1; next fetch address = 0x110.
  - Unequal operands: `PCWrite` low in stage 14; next fetch address = 0x104.
- **Load with memory waits:** `lw` with `mem_ready` low for 3 cycles in MEM_READ.
  - Required: state held at 5 with `mem_req` and `AdrSrc` stable.
  - MEM_WB follows on the cycle after `mem_ready` rises; total 8 cycles.
- **JAL:** `jal x1,+0x40` at PC 0x200.
  - Required: stages 0, 1, 8, 12.
  - Stage 12 writes x1 = 0x204 and sets PC = 0x240.
- **Illegal and reset:**
  - Opcode 1111111: → stage 17, `illegal`=1, `mem_req`=0 for ≥10 cycles.
  - Asserting `reset` mid-MEM_WRITE: state=0, `mem_we`=0 and `instret`=0 immediately, without a clock edge.

Source files
------------

// File: rtl/rv32i_mc_ctrl.sv
// Multicycle control FSM for the RV32I core.
// Decodes the latched instruction, sequences the one-cycle-latency ALU through
// its stages, and drives the operand muxes, write enables and memory handshake.
module rv32i_mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        Cond_Chk,
    input  logic        mem_ready,
    output logic [4:0]  current_stage,
    output logic [6:0]  opcode,
    output logic [3:0]  AluControl,
    output logic        PCSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic [1:0]  ResultSrc,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        mem_req,
    output logic        mem_we,
    output logic        AdrSrc,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [4:0] {
        S_FETCH      = 5'd0,
        S_DECODE     = 5'd1,
        S_EXEC_R     = 5'd2,
        S_ALU_WB     = 5'd3,
        S_LOAD_ADDR  = 5'd4,
        S_MEM_READ   = 5'd5,
        S_MEM_WB     = 5'd6,
        S_EXEC_I     = 5'd7,
        S_JAL_ADDR   = 5'd8,
        S_MEM_WRITE  = 5'd9,
        S_LUI        = 5'd10,
        S_AUIPC      = 5'd11,
        S_JUMP_WB    = 5'd12,
        S_JALR_ADDR  = 5'd13,
        S_BRANCH_UPD = 5'd14,
        S_STORE_ADDR = 5'd15,
        S_BRANCH_CMP = 5'd16,
        S_ILLEGAL    = 5'd17
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] A_PC = 2'd0, A_OLDPC = 2'd1, A_RS1 = 2'd2;
    localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

    state_t      state, state_nxt;
    logic        illegal_q;
    logic [31:0] instret_q;
    logic [2:0]  funct3;
    logic        mem_req_raw, mem_we_raw, ir_write_raw, pc_write_raw, reg_write_raw;
    logic        instr_unused;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign current_stage = state;
    assign illegal       = illegal_q;
    assign instret       = instret_q;
    assign instr_unused  = ^{instr[31], instr[29:15], instr[11:7]};

    // Next-state selection: opcode dispatch from DECODE, memory waits hold state
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:      if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:      state_nxt = S_EXEC_R;
                    OP_I:      state_nxt = S_EXEC_I;
                    OP_LOAD:   state_nxt = S_LOAD_ADDR;
                    OP_STORE:  state_nxt = S_STORE_ADDR;
                    OP_JAL:    state_nxt = S_JAL_ADDR;
                    OP_JALR:   state_nxt = S_JALR_ADDR;
                    OP_LUI:    state_nxt = S_LUI;
                    OP_AUIPC:  state_nxt = S_AUIPC;
                    OP_BRANCH: state_nxt = S_BRANCH_CMP;
                    default:   state_nxt = S_ILLEGAL;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC:          state_nxt = S_ALU_WB;
            S_ALU_WB, S_MEM_WB, S_JUMP_WB, S_BRANCH_UPD: state_nxt = S_FETCH;
            S_LOAD_ADDR:  state_nxt = S_MEM_READ;
            S_MEM_READ:   if (mem_ready) state_nxt = S_MEM_WB;
            S_STORE_ADDR: state_nxt = S_MEM_WRITE;
            S_MEM_WRITE:  if (mem_ready) state_nxt = S_FETCH;
            S_JAL_ADDR, S_JALR_ADDR: state_nxt = S_JUMP_WB;
            S_BRANCH_CMP: state_nxt = S_BRANCH_UPD;
            S_ILLEGAL:    state_nxt = S_ILLEGAL;
            default:      state_nxt = S_FETCH;
        endcase
    end

    // State register, sticky illegal flag and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE && state_nxt == S_ILLEGAL)
                illegal_q <= 1'b1;
            if (state != S_FETCH && state != S_ILLEGAL && state_nxt == S_FETCH)
                instret_q <= instret_q + 32'd1;
        end
    end

    // Per-state control decode; anything not driven by a state stays 0
    always_comb begin
        mem_req_raw   = 1'b0;
        mem_we_raw    = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        PCSrc         = 1'b0;
        ResultSrc     = 2'd0;
        ALUSrcA       = A_PC;
        ALUSrcB       = B_RS2;
        ImmSrc        = IMM_I;
        AluControl    = 4'b0000;
        case (state)
            S_FETCH: begin
                mem_req_raw  = 1'b1;
                ir_write_raw = mem_ready;
                ALUSrcB      = B_FOUR;
            end
            S_DECODE: begin
                pc_write_raw = 1'b1;
                ALUSrcA      = A_OLDPC;
                ALUSrcB      = B_IMM;
                ImmSrc       = IMM_B;
            end
            S_EXEC_R: begin
                ALUSrcA    = A_RS1;
                AluControl = {instr[30], funct3};
            end
            S_EXEC_I: begin
                ALUSrcA    = A_RS1;
                ALUSrcB    = B_IMM;
                // bit 30 only means "arithmetic" for shifts; for addi it is immediate data
                AluControl = {instr[30] & (funct3 == 3'b101), funct3};
            end
            S_LOAD_ADDR, S_JALR_ADDR: begin
                ALUSrcA = A_RS1;
                ALUSrcB = B_IMM;
            end
            S_STORE_ADDR: begin
                ALUSrcA = A_RS1;
                ALUSrcB = B_IMM;
                ImmSrc  = IMM_S;
            end
            S_JAL_ADDR: begin
                ALUSrcA = A_OLDPC;
                ALUSrcB = B_IMM;
                ImmSrc  = IMM_J;
            end
            S_AUIPC: begin
                ALUSrcA = A_OLDPC;
                ALUSrcB = B_IMM;
                ImmSrc  = IMM_U;
            end
            S_LUI: begin
                ALUSrcB = B_IMM;
                ImmSrc  = IMM_U;
            end
            S_BRANCH_CMP: begin
                ALUSrcA    = A_RS1;
                AluControl = {1'b1, funct3};
            end
            S_ALU_WB: reg_write_raw = 1'b1;
            S_MEM_READ: begin
                mem_req_raw = 1'b1;
                AdrSrc      = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_raw = 1'b1;
                ResultSrc     = 2'd1;
            end
            S_MEM_WRITE: begin
                mem_req_raw = 1'b1;
                mem_we_raw  = 1'b1;
                AdrSrc      = 1'b1;
            end
            S_JUMP_WB: begin
                // PC already holds PC+4 for the link; AluResult holds the jump target
                reg_write_raw = 1'b1;
                ResultSrc     = 2'd2;
                pc_write_raw  = 1'b1;
            end
            S_BRANCH_UPD: begin
                // target from DECODE is now on AluOut, compare from BRANCH_CMP on Cond_Chk
                PCSrc        = 1'b1;
                pc_write_raw = Cond_Chk;
            end
            default: ;
        endcase
    end

    // Reset asserts FETCH immediately, so strobes are masked while it is held
    assign mem_req  = mem_req_raw   & ~reset;
    assign mem_we   = mem_we_raw    & ~reset;
    assign IRWrite  = ir_write_raw  & ~reset;
    assign PCWrite  = pc_write_raw  & ~reset;
    assign RegWrite = reg_write_raw & ~reset;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Testbench for rv32i_mc_ctrl: directed instruction sequences, per-cycle
// expectations queued by the driver and checked by an independent monitor.
module tb_rv32i_mc_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        Cond_Chk;
    logic        mem_ready;
    logic [4:0]  current_stage;
    logic [6:0]  opcode;
    logic [3:0]  AluControl;
    logic        PCSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [1:0]  ResultSrc;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        mem_req;
    logic        mem_we;
    logic        AdrSrc;
    logic        illegal;
    logic [31:0] instret;

    rv32i_mc_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .Cond_Chk(Cond_Chk),
        .mem_ready(mem_ready), .current_stage(current_stage), .opcode(opcode),
        .AluControl(AluControl), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .mem_req(mem_req), .mem_we(mem_we), .AdrSrc(AdrSrc),
        .illegal(illegal), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [4:0]  st;
        logic [19:0] ctl;
        logic [6:0]  op;
        logic        ill;
        logic [31:0] ret;
    } exp_t;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] n_ret  = 0;
    logic [19:0] act;

    assign act = {mem_req, mem_we, AdrSrc, IRWrite, PCWrite, PCSrc, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, AluControl};

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, a, e);
        end
    endtask

    // control bundle in the same bit order as act
    function automatic logic [19:0] mk(input logic mreq, input logic we, input logic adr,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic rw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] imm, input logic [3:0] alu);
        return {mreq, we, adr, irw, pcw, pcs, rw, rs, a, b, imm, alu};
    endfunction

    // hand-written per-state control vectors
    function automatic logic [19:0] c_fetch(input logic mr);
        return mk(1, 0, 0, mr, 0, 0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 4'h0);
    endfunction
    localparam logic [19:0] C_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd0, 2'd1, 2'd1, 3'd2, 4'h0};
    localparam logic [19:0] C_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 4'h0};
    localparam logic [19:0] C_LADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 4'h0};
    localparam logic [19:0] C_MRD    = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 4'h0};
    localparam logic [19:0] C_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd1, 2'd0, 2'd0, 3'd0, 4'h0};
    localparam logic [19:0] C_SADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0, 2'd2, 2'd1, 3'd1, 4'h0};
    localparam logic [19:0] C_MWR    = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 4'h0};
    localparam logic [19:0] C_JAL    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0, 2'd1, 2'd1, 3'd4, 4'h0};
    localparam logic [19:0] C_JALR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 4'h0};
    localparam logic [19:0] C_JWB    = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 2'd2, 2'd0, 2'd0, 3'd0, 4'h0};
    localparam logic [19:0] C_LUI    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0, 2'd0, 2'd1, 3'd3, 4'h0};
    localparam logic [19:0] C_AUIPC  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0, 2'd1, 2'd1, 3'd3, 4'h0};
    localparam logic [19:0] C_BCMP   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0, 2'd2, 2'd0, 3'd0, 4'h8};
    localparam logic [19:0] C_ILL    = 20'h0;

    // one clock of stimulus: drive inputs just after the edge, queue what this cycle must show
    task automatic cyc(input string nm, input logic [31:0] w, input logic mr, input logic cc,
                       input logic [4:0] st, input logic [19:0] ctl, input logic ill);
        exp_t e;
        @(posedge clk);
        #1;
        instr     = w;
        mem_ready = mr;
        Cond_Chk  = cc;
        e.nm  = nm;
        e.st  = st;
        e.ctl = ctl;
        e.op  = w[6:0];
        e.ill = ill;
        e.ret = n_ret;
        q.push_back(e);
    endtask

    // monitor: the controller presents a full output set every cycle; check mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.nm, "/stage"},   {27'd0, current_stage}, {27'd0, e.st});
            chk({e.nm, "/ctl"},     {12'd0, act},           {12'd0, e.ctl});
            chk({e.nm, "/opcode"},  {25'd0, opcode},        {25'd0, e.op});
            chk({e.nm, "/illegal"}, {31'd0, illegal},       {31'd0, e.ill});
            chk({e.nm, "/instret"}, instret,                e.ret);
        end
    end

    task automatic run_alu(input string nm, input logic [31:0] w,
                           input logic [4:0] ex, input logic [19:0] exctl);
        cyc(nm, w, 1, 1, 5'd0, c_fetch(1), 0);
        cyc(nm, w, 1, 1, 5'd1, C_DEC, 0);
        cyc(nm, w, 1, 1, ex, exctl, 0);
        cyc(nm, w, 1, 1, 5'd3, C_ALUWB, 0);
        n_ret++;
    endtask

    task automatic run_branch(input string nm, input logic [31:0] w, input logic taken);
        cyc(nm, w, 1, ~taken, 5'd0, c_fetch(1), 0);
        cyc(nm, w, 1, ~taken, 5'd1, C_DEC, 0);
        cyc(nm, w, 1, ~taken, 5'd16, C_BCMP, 0);
        cyc(nm, w, 1, taken, 5'd14, mk(0, 0, 0, 0, taken, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'h0), 0);
        n_ret++;
    endtask

    task automatic run_jump(input string nm, input logic [31:0] w,
                            input logic [4:0] ex, input logic [19:0] exctl);
        cyc(nm, w, 1, 0, 5'd0, c_fetch(1), 0);
        cyc(nm, w, 1, 0, 5'd1, C_DEC, 0);
        cyc(nm, w, 1, 0, ex, exctl, 0);
        cyc(nm, w, 1, 0, 5'd12, C_JWB, 0);
        n_ret++;
    endtask

    // raise reset between clock edges, check its immediate effect, then release on a negedge
    task automatic async_reset(input string nm);
        #5;
        reset = 1'b1;
        #1;
        chk({nm, "/stage"},   {27'd0, current_stage}, 32'd0);
        chk({nm, "/mem_req"}, {31'd0, mem_req},       32'd0);
        chk({nm, "/mem_we"},  {31'd0, mem_we},        32'd0);
        chk({nm, "/illegal"}, {31'd0, illegal},       32'd0);
        chk({nm, "/instret"}, instret,                32'd0);
        mem_ready = 1'b0;
        n_ret     = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_SRAI  = 32'h4030D093;
    localparam logic [31:0] I_ADDI  = 32'hC0000093;
    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_AUIPC = 32'h00000097;
    localparam logic [31:0] I_BEQ   = 32'h00208863;
    localparam logic [31:0] I_LW    = 32'h0000A283;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_JAL   = 32'h040000EF;
    localparam logic [31:0] I_JALR  = 32'h00008067;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        Cond_Chk  = 1'b1;
        instr     = I_ADD;
        #3;
        chk("rst/stage",   {27'd0, current_stage}, 32'd0);
        chk("rst/mem_req", {31'd0, mem_req},       32'd0);
        chk("rst/IRWrite", {31'd0, IRWrite},       32'd0);
        chk("rst/PCWrite", {31'd0, PCWrite},       32'd0);
        chk("rst/illegal", {31'd0, illegal},       32'd0);
        chk("rst/instret", instret,                32'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        cyc("fetch_wait", I_ADD, 0, 0, 5'd0, c_fetch(0), 0);
        run_alu("add",   I_ADD,   5'd2,  mk(0,0,0,0,0,0,0, 2'd0, 2'd2, 2'd0, 3'd0, 4'h0));
        run_alu("sub",   I_SUB,   5'd2,  mk(0,0,0,0,0,0,0, 2'd0, 2'd2, 2'd0, 3'd0, 4'h8));
        run_alu("srai",  I_SRAI,  5'd7,  mk(0,0,0,0,0,0,0, 2'd0, 2'd2, 2'd1, 3'd0, 4'hD));
        run_alu("addi",  I_ADDI,  5'd7,  mk(0,0,0,0,0,0,0, 2'd0, 2'd2, 2'd1, 3'd0, 4'h0));
        run_alu("lui",   I_LUI,   5'd10, C_LUI);
        run_alu("auipc", I_AUIPC, 5'd11, C_AUIPC);
        run_branch("beq_taken", I_BEQ, 1'b1);
        run_branch("beq_not",   I_BEQ, 1'b0);

        // load, three wait cycles in MEM_READ: 8 cycles total
        cyc("lw", I_LW, 1, 0, 5'd0, c_fetch(1), 0);
        cyc("lw", I_LW, 1, 0, 5'd1, C_DEC, 0);
        cyc("lw", I_LW, 0, 0, 5'd4, C_LADDR, 0);
        for (int i = 0; i < 3; i++)
            cyc("lw_wait", I_LW, 0, 0, 5'd5, C_MRD, 0);
        cyc("lw_done", I_LW, 1, 0, 5'd5, C_MRD, 0);
        cyc("lw", I_LW, 1, 0, 5'd6, C_MWB, 0);
        n_ret++;

        // store with one fetch wait and one write wait
        cyc("sw", I_SW, 0, 0, 5'd0, c_fetch(0), 0);
        cyc("sw", I_SW, 1, 0, 5'd0, c_fetch(1), 0);
        cyc("sw", I_SW, 1, 0, 5'd1, C_DEC, 0);
        cyc("sw", I_SW, 0, 0, 5'd15, C_SADDR, 0);
        cyc("sw_wait", I_SW, 0, 0, 5'd9, C_MWR, 0);
        cyc("sw", I_SW, 1, 0, 5'd9, C_MWR, 0);
        n_ret++;

        run_jump("jal",  I_JAL,  5'd8,  C_JAL);
        run_jump("jalr", I_JALR, 5'd13, C_JALR);

        // unknown opcode: terminal, mem_ready must have no effect
        cyc("bad", I_BAD, 1, 1, 5'd0, c_fetch(1), 0);
        cyc("bad", I_BAD, 1, 1, 5'd1, C_DEC, 0);
        for (int i = 0; i < 10; i++)
            cyc("bad_hold", I_BAD, 1, 1, 5'd17, C_ILL, 1);
        async_reset("rst_illegal");

        // reset while a store waits on memory
        cyc("sw2", I_SW, 1, 0, 5'd0, c_fetch(1), 0);
        cyc("sw2", I_SW, 1, 0, 5'd1, C_DEC, 0);
        cyc("sw2", I_SW, 0, 0, 5'd15, C_SADDR, 0);
        cyc("sw2_wait", I_SW, 0, 0, 5'd9, C_MWR, 0);
        async_reset("rst_memwrite");

        cyc("fetch_wait2", I_ADD, 0, 0, 5'd0, c_fetch(0), 0);
        run_alu("add2", I_ADD, 5'd2, mk(0,0,0,0,0,0,0, 2'd0, 2'd2, 2'd0, 3'd0, 4'h0));
        cyc("tail", I_ADD, 0, 0, 5'd0, c_fetch(0), 0);

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d expectations pending, expected 0", q.size());
        $fatal(1, "watchdog");
    end

endmodule
